// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, FSM state types and frame-length helper.
package uart_pkg;

  localparam int unsigned NBITS_DEF  = 8;
  localparam int unsigned STICKS_DEF = 16;

  function automatic int unsigned frame_bits(input int unsigned nbits);
    return nbits + 2;
  endfunction

  localparam int unsigned FRAME_BITS = frame_bits(NBITS_DEF);

  typedef enum logic [2:0] {
    M_IDLE,
    M_TX_START,
    M_TX_DATA,
    M_TX_STOP,
    M_RX,
    M_DONE
  } master_state_e;

  typedef enum logic [1:0] {
    R_WAIT,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-FF rx synchronizer, start-bit validation, LSB-first shift, stop check.
// Held in R_WAIT while en_i is low; hunting_o marks the idle-line state.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned Nbits  = NBITS_DEF,
  parameter int unsigned Sticks = STICKS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             rx_i,
  output logic [Nbits-1:0] byte_o,
  output logic             valid_o,
  output logic             ferr_o,
  output logic             hunting_o
);

  localparam int unsigned   TW        = $clog2(Sticks);
  localparam int unsigned   BW        = (Nbits > 1) ? $clog2(Nbits) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(Sticks - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(Sticks / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(Nbits - 1);

  rx_state_e        state;
  logic             rx_meta;
  logic             rx_sync;
  logic [TW-1:0]    tcnt;
  logic [BW-1:0]    bcnt;
  logic [Nbits-1:0] shreg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign hunting_o = (state == R_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= R_WAIT;
      tcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      byte_o  <= '0;
      valid_o <= 1'b0;
      ferr_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!en_i) begin
        state <= R_WAIT;
        tcnt  <= '0;
        bcnt  <= '0;
      end else begin
        unique case (state)
          R_WAIT: begin
            if (!rx_sync) begin
              tcnt  <= '0;
              state <= R_START;
            end
          end
          R_START: begin
            if (tick_i) begin
              if (tcnt == TICK_MID) begin
                tcnt  <= '0;
                bcnt  <= '0;
                state <= rx_sync ? R_WAIT : R_DATA;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          R_DATA: begin
            if (tick_i) begin
              if (tcnt == TICK_LAST) begin
                tcnt  <= '0;
                shreg <= {rx_sync, shreg[Nbits-1:1]};
                if (bcnt == BIT_LAST) begin
                  state <= R_STOP;
                end else begin
                  bcnt <= bcnt + 1'b1;
                end
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          R_STOP: begin
            if (tick_i) begin
              if (tcnt == TICK_LAST) begin
                // Byte is delivered even with a bad stop bit; ferr_o qualifies it.
                tcnt    <= '0;
                byte_o  <= shreg;
                valid_o <= 1'b1;
                ferr_o  <= ~rx_sync;
                state   <= R_WAIT;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
          default: state <= R_WAIT;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: sends one command byte, then collects NumRsp
// response bytes, ending each transaction with done_o or timeout_o.
module uart_cmd_master
  import uart_pkg::*;
#(
  parameter int unsigned Nbits        = NBITS_DEF,
  parameter int unsigned Sticks       = STICKS_DEF,
  parameter int unsigned NumRsp       = 1,
  parameter int unsigned TimeoutBits  = 16,
  parameter int unsigned TimeoutTicks = 40000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic [Nbits-1:0] cmd_i,
  input  logic             rx_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic [Nbits-1:0] rsp_o,
  output logic             rsp_valid_o,
  output logic             frame_err_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int unsigned            TW        = $clog2(Sticks);
  localparam int unsigned            BW        = (Nbits > 1) ? $clog2(Nbits) : 1;
  localparam int unsigned            RW        = $clog2(NumRsp + 1);
  localparam logic [TW-1:0]          TICK_LAST = TW'(Sticks - 1);
  localparam logic [BW-1:0]          BIT_LAST  = BW'(Nbits - 1);
  localparam logic [RW-1:0]          RSP_LAST  = RW'(NumRsp - 1);
  localparam logic [TimeoutBits-1:0] TOUT_LAST = TimeoutBits'(TimeoutTicks - 1);

  master_state_e          state;
  logic [Nbits-1:0]       tx_data;
  logic [TW-1:0]          tcnt;
  logic [BW-1:0]          bcnt;
  logic [RW-1:0]          byte_cnt;
  logic [TimeoutBits-1:0] tout_cnt;
  logic                   rx_en;
  logic                   rx_ferr;
  logic                   rx_hunting;

  assign rx_en = (state == M_RX);

  uart_rx_frame #(
    .Nbits  (Nbits),
    .Sticks (Sticks)
  ) u_rx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (rx_en),
    .tick_i    (tick_i),
    .rx_i      (rx_i),
    .byte_o    (rsp_o),
    .valid_o   (rsp_valid_o),
    .ferr_o    (rx_ferr),
    .hunting_o (rx_hunting)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= M_IDLE;
      tx_o        <= 1'b1;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      tx_data     <= '0;
      tcnt        <= '0;
      bcnt        <= '0;
      byte_cnt    <= '0;
      tout_cnt    <= '0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      unique case (state)
        M_IDLE: begin
          if (start_i) begin
            tx_data     <= cmd_i;
            tx_o        <= 1'b0;
            busy_o      <= 1'b1;
            frame_err_o <= 1'b0;
            tcnt        <= '0;
            state       <= M_TX_START;
          end
        end
        M_TX_START: begin
          if (tick_i) begin
            if (tcnt == TICK_LAST) begin
              tcnt    <= '0;
              bcnt    <= '0;
              tx_o    <= tx_data[0];
              tx_data <= {1'b0, tx_data[Nbits-1:1]};
              state   <= M_TX_DATA;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        M_TX_DATA: begin
          if (tick_i) begin
            if (tcnt == TICK_LAST) begin
              tcnt <= '0;
              if (bcnt == BIT_LAST) begin
                tx_o  <= 1'b1;
                state <= M_TX_STOP;
              end else begin
                tx_o    <= tx_data[0];
                tx_data <= {1'b0, tx_data[Nbits-1:1]};
                bcnt    <= bcnt + 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        M_TX_STOP: begin
          if (tick_i) begin
            if (tcnt == TICK_LAST) begin
              tcnt     <= '0;
              tout_cnt <= '0;
              byte_cnt <= '0;
              state    <= M_RX;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        M_RX: begin
          if (rsp_valid_o) begin
            if (rx_ferr) begin
              frame_err_o <= 1'b1;
            end
            tout_cnt <= '0;
            if (byte_cnt == RSP_LAST) begin
              state <= M_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (rx_hunting && tick_i) begin
            // Timeout is judged only while the line is idle, so a frame in flight always completes.
            if (tout_cnt == TOUT_LAST) begin
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= M_IDLE;
            end else if (tout_cnt != '1) begin
              tout_cnt <= tout_cnt + 1'b1;
            end
          end
        end
        M_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= M_IDLE;
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: transaction-level model of the serial
// frames, response delivery and timeout, compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_uart_cmd_master;
  import uart_pkg::*;

  localparam int unsigned NB       = 8;
  localparam int unsigned ST       = 16;
  localparam int unsigned NR       = 2;
  localparam int unsigned TO       = 200;
  localparam int unsigned BIT_CLK  = ST * 4;
  localparam int unsigned TX_TICKS = FRAME_BITS * ST;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          tick  = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] cmd   = '0;
  logic          rx    = 1'b1;
  logic          tx_o;
  logic          busy_o;
  logic [NB-1:0] rsp_o;
  logic          rsp_valid_o;
  logic          frame_err_o;
  logic          done_o;
  logic          timeout_o;

  uart_cmd_master #(
    .Nbits        (NB),
    .Sticks       (ST),
    .NumRsp       (NR),
    .TimeoutBits  (16),
    .TimeoutTicks (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .start_i     (start),
    .cmd_i       (cmd),
    .rx_i        (rx),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .rsp_o       (rsp_o),
    .rsp_valid_o (rsp_valid_o),
    .frame_err_o (frame_err_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int unsigned tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    tick = (tdiv == 0);
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model state
  bit            m_busy = 0;
  int unsigned   m_ticks = 0;
  logic [NB-1:0] m_cmd = '0;
  logic [NB-1:0] m_last_rsp = '0;
  bit            m_ferr = 0;
  bit            m_ferr_pend = 0;
  bit            m_tout_exp = 0;
  int unsigned   m_tout_lo = 0;
  int unsigned   m_tout_hi = 0;
  int            m_rx_cnt = 0;
  int            since_valid = 999;
  bit            in_stop = 0;
  int            n_done = 0;
  int            n_tout = 0;
  int            n_valid = 0;
  logic [NB-1:0] exp_q[$];
  bit            ef_q[$];

  function automatic logic exp_tx();
    logic [9:0]  fr;
    int unsigned idx;
    if (!m_busy) return 1'b1;
    fr  = {1'b1, m_cmd, 1'b0};
    idx = m_ticks / ST;
    if (idx >= FRAME_BITS) return 1'b1;
    return fr[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_ticks = 0; m_ferr = 0; m_ferr_pend = 0;
      m_last_rsp = '0; m_rx_cnt = 0;
      exp_q.delete(); ef_q.delete();
    end else begin
      if (m_ferr_pend) m_ferr = 1;
      m_ferr_pend = 0;
      if (!m_busy && start) begin
        m_busy = 1; m_cmd = cmd; m_ticks = 0; m_ferr = 0;
        m_rx_cnt = 0; since_valid = 999;
      end else if (m_busy && tick) begin
        m_ticks++;
      end
    end
    #1;
    since_valid++;
    chk("tx_o", tx_o, exp_tx());
    if (rsp_valid_o) begin
      n_valid++;
      if (exp_q.size() == 0 || !m_busy) begin
        chk("rsp_valid_unexpected", rsp_valid_o, 1'b0);
      end else begin
        m_last_rsp = exp_q.pop_front();
        if (ef_q.pop_front()) m_ferr_pend = 1;
        chk("rsp_valid_in_stop_bit", in_stop, 1'b1);
        m_rx_cnt++;
        since_valid = 0;
      end
    end
    chk("rsp_o", rsp_o, m_last_rsp);
    if (done_o) begin
      n_done++;
      chk("done_timing", (m_busy && m_rx_cnt == NR && since_valid >= 1 && since_valid <= 3), 1'b1);
      m_busy = 0;
    end
    if (timeout_o) begin
      n_tout++;
      chk("timeout_tick", m_ticks, (m_busy && m_tout_exp && m_ticks >= m_tout_lo &&
                                    m_ticks <= m_tout_hi) ? m_ticks : m_tout_lo);
      m_busy = 0;
    end else if (m_busy && m_tout_exp && m_ticks > m_tout_hi) begin
      chk("timeout_missing", m_ticks, m_tout_hi);
      m_tout_exp = 0;
      m_busy = 0;
    end
    chk("busy_o", busy_o, m_busy);
    chk("frame_err_o", frame_err_o, m_ferr);
  end

  task automatic do_start(input logic [NB-1:0] c);
    @(negedge clk);
    start = 1'b1; cmd = c;
    @(negedge clk);
    start = 1'b0; cmd = NB'($urandom);
  endtask

  task automatic wait_ticks(input int unsigned k, input string nm);
    int n = 0;
    while (m_ticks < k && m_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (m_ticks < k) chk(nm, m_ticks, k);
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int n = 0;
    while (m_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) chk(nm, m_busy, 1'b0);
  endtask

  task automatic send_byte(input logic [NB-1:0] b, input bit stop_ok);
    exp_q.push_back(b);
    ef_q.push_back(!stop_ok);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    in_stop = 1;
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK - 48) @(negedge clk);
    end
    in_stop = 0;
  endtask

  task automatic respond(input logic [NB-1:0] b0, input bit ok0, input logic [NB-1:0] b1, input bit ok1);
    int d0 = n_done;
    int v0 = n_valid;
    wait_ticks(TX_TICKS, "tx_end_reached");
    repeat ($urandom_range(0, 300)) @(negedge clk);
    send_byte(b0, ok0);
    repeat (ok0 ? $urandom_range(0, 200) : $urandom_range(100, 200)) @(negedge clk);
    send_byte(b1, ok1);
    repeat (ok1 ? 0 : 32) @(negedge clk);
    wait_idle(200, "done_reached");
    chk("done_count", n_done, d0 + 1);
    chk("rsp_valid_count", n_valid, v0 + 2);
    chk("rsp_queue_drained", exp_q.size(), 0);
    exp_q.delete(); ef_q.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic txn_data(input logic [NB-1:0] c, input logic [NB-1:0] b0, input bit ok0,
                          input logic [NB-1:0] b1, input bit ok1);
    m_tout_exp = 0;
    do_start(c);
    respond(b0, ok0, b1, ok1);
  endtask

  task automatic txn_silent(input logic [NB-1:0] c, input bit glitch);
    int t0 = n_tout;
    int v0 = n_valid;
    m_tout_exp = 1;
    m_tout_lo  = TX_TICKS + TO;
    m_tout_hi  = glitch ? TX_TICKS + TO + 12 : TX_TICKS + TO;
    do_start(c);
    if (glitch) begin
      wait_ticks(TX_TICKS, "tx_end_reached");
      repeat ($urandom_range(100, 300)) @(negedge clk);
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
    end
    wait_idle(4000, "timeout_reached");
    chk("timeout_count", n_tout, t0 + 1);
    chk("no_rsp_on_timeout", n_valid, v0);
    m_tout_exp = 0;
    repeat (20) @(negedge clk);
  endtask

  bit a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_o", tx_o, 1'b1);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_rsp_o", rsp_o, 8'h00);
    chk("rst_rsp_valid_o", rsp_valid_o, 1'b0);
    chk("rst_frame_err_o", frame_err_o, 1'b0);
    chk("rst_done_o", done_o, 1'b0);
    chk("rst_timeout_o", timeout_o, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of the data bits
    do_start(8'h5A);
    wait_ticks(40, "reach_tx_data");
    rst = 1'b1;
    #1;
    chk("async_rst_tx_o", tx_o, 1'b1);
    chk("async_rst_busy_o", busy_o, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // A5 command, bits pinned at their centres; a busy-time start with FF is ignored
    m_tout_exp = 0;
    do_start(8'hA5);
    for (int i = 0; i < 10; i++) begin
      wait_ticks(ST * i + 8, "a5_bit_reached");
      chk("a5_bit", tx_o, a5_bits[i]);
      chk("a5_busy", busy_o, 1'b1);
      if (i == 2) begin
        start = 1'b1; cmd = 8'hFF;
        @(negedge clk);
        start = 1'b0;
      end
    end
    respond(8'h3C, 1'b1, 8'hC3, 1'b1);
    chk("a5_last_rsp", rsp_o, 8'hC3);
    chk("a5_frame_err", frame_err_o, 1'b0);

    txn_silent(8'h11, 1'b0);
    txn_silent(8'h22, 1'b1);

    txn_data(8'h0F, 8'h55, 1'b0, 8'h9A, 1'b1);
    chk("ferr_sticky", frame_err_o, 1'b1);
    chk("ferr_last_rsp", rsp_o, 8'h9A);

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 3) == 0)
        txn_silent(NB'($urandom), 1'($urandom_range(0, 1)));
      else
        txn_data(NB'($urandom), NB'($urandom), ($urandom_range(0, 3) != 0),
                 NB'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
